// File: rtl/banco_escritura_if.sv
// banco_escritura_if
// Bundles the write handshake, the clear control and the sixteen register
// outputs of the register bank write side.
//   wr_valid / wr_ready : write handshake (master -> bank / bank -> master)
//   selecw, dato        : target index and write data
//   clr_req / busy      : bulk clear request and sweep-in-progress flag
//   R_0 .. R_15         : current register contents for the read multiplexer
// The master modport is the requester side; the slave modport is the bank.
interface banco_escritura_if #(
  parameter int N = 16
);
  logic         wr_valid;
  logic         wr_ready;
  logic [3:0]   selecw;
  logic [N-1:0] dato;
  logic         clr_req;
  logic         busy;
  logic [N-1:0] R_0,  R_1,  R_2,  R_3,  R_4,  R_5,  R_6,  R_7;
  logic [N-1:0] R_8,  R_9,  R_10, R_11, R_12, R_13, R_14, R_15;

  modport master (
    output wr_valid, selecw, dato, clr_req,
    input  wr_ready, busy,
    input  R_0, R_1, R_2,  R_3,  R_4,  R_5,  R_6,  R_7,
    input  R_8, R_9, R_10, R_11, R_12, R_13, R_14, R_15
  );

  modport slave (
    input  wr_valid, selecw, dato, clr_req,
    output wr_ready, busy,
    output R_0, R_1, R_2,  R_3,  R_4,  R_5,  R_6,  R_7,
    output R_8, R_9, R_10, R_11, R_12, R_13, R_14, R_15
  );
endinterface

// File: rtl/banco_escritura.sv
// banco_escritura
// Write side of a 16-entry register bank. One write per cycle is accepted
// through a valid/ready handshake while idle. A clear request starts a
// sweep that zeroes one register per cycle (index 0 first); writes stall
// for the 16 cycles of the sweep.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous active-high reset, overrides everything
//   bus   : slave side of banco_escritura_if (handshake, clear, R_0..R_15)
module banco_escritura #(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                reset,
  banco_escritura_if.slave    bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [3:0]   cnt;
  logic [N-1:0] bank [16];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a sampled clear request in IDLE starts the sweep;
  // the sweep always ends after index 15, clear requests during it are ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.clr_req) state_next = CLEAR;
      CLEAR:   if (cnt == 4'd15) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs, decoded purely from the registered state.
  always_comb begin
    bus.wr_ready = 1'b0;
    bus.busy     = 1'b0;
    case (state)
      IDLE:    bus.wr_ready = 1'b1;
      CLEAR:   bus.busy     = 1'b1;
      default: bus.wr_ready = 1'b0;
    endcase
  end

  // Sweep counter: runs only in CLEAR and wraps from 15 back to 0, so it is
  // already 0 when the next sweep begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= 4'd0;
    end
  end

  // Register storage. In IDLE an accepted write updates one entry (even on
  // the edge that starts a sweep; the sweep reaches it later). In CLEAR the
  // entry under the sweep counter is zeroed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        bank[i] <= '0;
      end
    end else if (state == IDLE) begin
      if (bus.wr_valid) begin
        bank[bus.selecw] <= bus.dato;
      end
    end else begin
      bank[cnt] <= '0;
    end
  end

  assign bus.R_0  = bank[0];
  assign bus.R_1  = bank[1];
  assign bus.R_2  = bank[2];
  assign bus.R_3  = bank[3];
  assign bus.R_4  = bank[4];
  assign bus.R_5  = bank[5];
  assign bus.R_6  = bank[6];
  assign bus.R_7  = bank[7];
  assign bus.R_8  = bank[8];
  assign bus.R_9  = bank[9];
  assign bus.R_10 = bank[10];
  assign bus.R_11 = bank[11];
  assign bus.R_12 = bank[12];
  assign bus.R_13 = bank[13];
  assign bus.R_14 = bank[14];
  assign bus.R_15 = bank[15];

endmodule
